// File: rtl/configs_loader.sv
// configs_loader: setup/strobe/hold sequencer loading config words into a latch bank; define CFG_PARITY_EN for even-parity checking
module configs_loader #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 14,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WORD_W-1:0]    io_in_bits,
`ifdef CFG_PARITY_EN
  input  logic                 io_in_parity,
  output logic                 io_err,
`endif
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done
);
  typedef enum logic [2:0] {IDLE, WAIT, SETUP, STROBE, HOLD, DONE} state_t;
  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WORD_W-1:0]      d_q, d_d;
  logic [NUM_WORDS-1:0]   en_q, en_d;
  logic                   ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic                   par_bad, last;
`ifdef CFG_PARITY_EN
  logic                   err_q, err_d;
  assign par_bad = ^{io_in_bits, io_in_parity};
  assign io_err  = err_q;
`else
  assign par_bad = 1'b0;
`endif
  assign last          = idx_q == IDX_W'(NUM_WORDS - 1);
  assign io_in_ready   = ready_q;
  assign io_d_out      = d_q;
  assign io_configs_en = en_q;
  assign io_busy       = busy_q;
  assign io_done       = done_q;
  // Next state plus next values of every registered output, decoded from the state being entered
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    d_d     = d_q;
    case (state_q)
      IDLE:    if (io_start) begin
                 state_d = WAIT;
                 idx_d   = '0;
               end
      WAIT:    if (io_in_valid) begin
                 state_d = par_bad ? IDLE : SETUP;
                 d_d     = par_bad ? d_q : io_in_bits;
               end
      SETUP:   state_d = STROBE;
      STROBE:  state_d = HOLD;
      HOLD:    begin
                 state_d = last ? DONE : WAIT;
                 idx_d   = last ? idx_q : idx_q + IDX_W'(1);
               end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = state_d == WAIT;
    busy_d  = state_d != IDLE;
    done_d  = state_d == DONE;
    en_d    = (state_d == STROBE) ? NUM_WORDS'(1) << idx_d : '0;
  end
  // State and output registers; async reset drops the latch enables without waiting for an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      d_q     <= '0;
      en_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
`ifdef CFG_PARITY_EN
  // Sticky parity error: set on a bad accepted word, cleared when a new load starts
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && io_start) err_d = 1'b0;
    else if (state_q == WAIT && io_in_valid && par_bad) err_d = 1'b1;
  end
  // Parity error flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else err_q <= err_d;
  end
`endif
endmodule

// File: tb/tb_configs_loader.sv
// tb_configs_loader: randomized self-checking bench for configs_loader against a word-list/timing model
module tb_configs_loader;
  localparam int N = 14;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b1, io_start = 1'b0, io_in_valid = 1'b0;
  logic io_in_ready, io_busy, io_done;
  logic [W-1:0] io_in_bits = '0, io_d_out;
  logic [N-1:0] io_configs_en;
`ifdef CFG_PARITY_EN
  logic io_in_parity = 1'b0, io_err;
  int bad_idx = -1;
`endif
  int tests = 0, fails = 0;
  logic [W-1:0] words [N];
  int obs_pos[$];
  logic [W-1:0] obs_data[$];
  int done_cnt, done_e, onehot_viol, data_viol, stall_en_viol, k_final;

  always #5 clk = ~clk;

  configs_loader #(.WORD_W(W), .NUM_WORDS(N), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .io_start(io_start), .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready), .io_in_bits(io_in_bits),
`ifdef CFG_PARITY_EN
    .io_in_parity(io_in_parity), .io_err(io_err),
`endif
    .io_d_out(io_d_out), .io_configs_en(io_configs_en), .io_busy(io_busy), .io_done(io_done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  // Drives one load from a negedge in IDLE: start pulse, then words with valid high whenever not stalling.
  // Observes strobes, data stability, done pulses at every negedge; e counts edges after the start edge.
  task automatic run_load(input int stall_word, input int stall_len, input bit start_noise, input int ncycles);
    int k, st;
    logic [N-1:0] en, prev_en;
    logic [W-1:0] d, prev_d;
    bit stalling, accepted;
    obs_pos.delete(); obs_data.delete();
    done_cnt = 0; done_e = -1; onehot_viol = 0; data_viol = 0; stall_en_viol = 0;
    k = 0; st = stall_len; prev_en = '0; prev_d = io_d_out;
    io_start = 1'b1; io_in_valid = 1'b0;
    @(negedge clk);
    io_start = 1'b0;
    for (int e = 0; e < ncycles; e++) begin
      en = io_configs_en; d = io_d_out;
      if ($countones(en) > 1) onehot_viol++;
      if (en != '0) begin
        for (int b = 0; b < N; b++) if (en[b]) obs_pos.push_back(b);
        obs_data.push_back(d);
        if (d !== prev_d) data_viol++;
      end
      if (prev_en != '0 && d !== prev_d) data_viol++;
      if (io_done === 1'b1) begin
        if (done_cnt == 0) done_e = e;
        done_cnt++;
      end
      stalling = (k == stall_word) && (st > 0) && (io_in_ready === 1'b1);
      if (stalling) begin
        st--;
        if (en != '0) stall_en_viol++;
      end
      io_in_valid = (k < N) && !stalling;
      io_in_bits = (k < N) ? words[k] : '0;
`ifdef CFG_PARITY_EN
      io_in_parity = (k == bad_idx) ? ~(^io_in_bits) : ^io_in_bits;
`endif
      io_start = start_noise && (e % 5 == 2) && (e < 4 * N - 8);
      accepted = io_in_valid && (io_in_ready === 1'b1);
      prev_en = en; prev_d = d;
      @(negedge clk);
      if (accepted) k++;
    end
    io_in_valid = 1'b0; io_start = 1'b0; k_final = k;
  endtask

  task automatic test_reset;
    #2;
    tests++; if (io_configs_en !== '0) begin fails++; $display("FAIL reset_en: got %h, want 0", io_configs_en); end
    tests++; if (io_d_out !== '0) begin fails++; $display("FAIL reset_dout: got %h, want 0", io_d_out); end
    tests++; if (io_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, want 0", io_done); end
    tests++; if (io_busy !== 1'b0 || io_in_ready !== 1'b0) begin fails++; $display("FAIL reset_busy_ready: got busy=%b ready=%b, want 0 0", io_busy, io_in_ready); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (io_busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b, want 0", io_busy); end
  endtask

  task automatic test_full_load;
    for (int i = 0; i < N; i++) words[i] = 32'h1000_0000 + i;
    run_load(-1, 0, 1'b0, 4 * N + 1);
    tests++; if (obs_pos.size() != N) begin fails++; $display("FAIL full_count: got %0d strobes, want %0d", obs_pos.size(), N); end
    for (int i = 0; i < N && i < obs_pos.size(); i++) begin
      tests++;
      if (obs_pos[i] != i || obs_data[i] !== words[i]) begin fails++; $display("FAIL full_word%0d: got en[%0d] data %h, want en[%0d] data %h", i, obs_pos[i], obs_data[i], i, words[i]); end
    end
    tests++; if (done_e != 4 * N || done_cnt != 1) begin fails++; $display("FAIL full_done: got at edge %0d count %0d, want edge %0d count 1", done_e, done_cnt, 4 * N); end
    tests++; if (onehot_viol != 0 || data_viol != 0) begin fails++; $display("FAIL full_stability: got onehot_viol=%0d data_viol=%0d, want 0 0", onehot_viol, data_viol); end
    tests++; if (io_busy !== 1'b0 || io_done !== 1'b0) begin fails++; $display("FAIL full_after: got busy=%b done=%b, want 0 0", io_busy, io_done); end
    tests++; if (io_d_out !== words[N-1]) begin fails++; $display("FAIL full_keep_dout: got %h, want %h", io_d_out, words[N-1]); end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < N; i++) words[i] = $urandom;
    run_load(3, 5, 1'b0, 4 * N + 6);
    tests++; if (obs_pos.size() != N) begin fails++; $display("FAIL bp_count: got %0d strobes, want %0d", obs_pos.size(), N); end
    for (int i = 0; i < N && i < obs_pos.size(); i++) begin
      tests++;
      if (obs_pos[i] != i || obs_data[i] !== words[i]) begin fails++; $display("FAIL bp_word%0d: got en[%0d] data %h, want en[%0d] data %h", i, obs_pos[i], obs_data[i], i, words[i]); end
    end
    tests++; if (done_e != 4 * N + 5) begin fails++; $display("FAIL bp_done: got edge %0d, want %0d", done_e, 4 * N + 5); end
    tests++; if (stall_en_viol != 0 || data_viol != 0) begin fails++; $display("FAIL bp_stall: got en_during_stall=%0d data_viol=%0d, want 0 0", stall_en_viol, data_viol); end
  endtask

  task automatic test_reset_mid;
    int k;
    bit found, acc;
    int dn;
    for (int i = 0; i < N; i++) words[i] = $urandom;
    k = 0; found = 1'b0; dn = 0;
    io_start = 1'b1;
    @(negedge clk);
    io_start = 1'b0;
    for (int e = 0; e < 100 && !found; e++) begin
      if (io_configs_en[6] === 1'b1) found = 1'b1;
      else begin
        io_in_valid = 1'b1; io_in_bits = words[k];
`ifdef CFG_PARITY_EN
        io_in_parity = ^io_in_bits;
`endif
        acc = io_in_ready === 1'b1;
        @(negedge clk);
        if (acc) k++;
      end
    end
    io_in_valid = 1'b0;
    tests++; if (!found) begin fails++; $display("FAIL rmid_strobe6: got no en[6], want en[6] within 100 cycles"); end
    #2 reset = 1'b1;
    #1;
    tests++; if (io_configs_en !== '0) begin fails++; $display("FAIL rmid_en_async: got %h, want 0", io_configs_en); end
    tests++; if (io_d_out !== '0 || io_busy !== 1'b0) begin fails++; $display("FAIL rmid_state: got dout=%h busy=%b, want 0 0", io_d_out, io_busy); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (io_done === 1'b1) dn++;
    end
    tests++; if (dn != 0) begin fails++; $display("FAIL rmid_no_done: got %0d done pulses, want 0", dn); end
    for (int i = 0; i < N; i++) words[i] = $urandom;
    run_load(-1, 0, 1'b0, 4 * N + 1);
    tests++; if (obs_pos.size() != N || obs_pos[0] != 0 || obs_data[0] !== words[0]) begin fails++; $display("FAIL rmid_restart: got %0d strobes first en[%0d], want %0d strobes first en[0]", obs_pos.size(), (obs_pos.size() > 0) ? obs_pos[0] : -1, N); end
    tests++; if (done_e != 4 * N) begin fails++; $display("FAIL rmid_restart_done: got edge %0d, want %0d", done_e, 4 * N); end
  endtask

  task automatic test_start_noise;
    for (int i = 0; i < N; i++) words[i] = $urandom;
    run_load(-1, 0, 1'b1, 4 * N + 1);
    tests++; if (k_final != N) begin fails++; $display("FAIL noise_consumed: got %0d words taken, want %0d", k_final, N); end
    tests++; if (obs_pos.size() != N) begin fails++; $display("FAIL noise_count: got %0d strobes, want %0d", obs_pos.size(), N); end
    for (int i = 0; i < N && i < obs_pos.size(); i++) begin
      tests++;
      if (obs_pos[i] != i || obs_data[i] !== words[i]) begin fails++; $display("FAIL noise_word%0d: got en[%0d] data %h, want en[%0d] data %h", i, obs_pos[i], obs_data[i], i, words[i]); end
    end
    tests++; if (done_e != 4 * N || onehot_viol != 0) begin fails++; $display("FAIL noise_done: got edge %0d onehot_viol %0d, want edge %0d viol 0", done_e, onehot_viol, 4 * N); end
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) words[i] = $urandom;
      run_load(-1, 0, 1'b0, 4 * N + 1);
      tests++; if (obs_pos.size() != N) begin fails++; $display("FAIL b2b%0d_count: got %0d strobes, want %0d", r, obs_pos.size(), N); end
      for (int i = 0; i < N && i < obs_pos.size(); i++) begin
        tests++;
        if (obs_pos[i] != i || obs_data[i] !== words[i]) begin fails++; $display("FAIL b2b%0d_word%0d: got en[%0d] data %h, want en[%0d] data %h", r, i, obs_pos[i], obs_data[i], i, words[i]); end
      end
      tests++; if (done_e != 4 * N || done_cnt != 1) begin fails++; $display("FAIL b2b%0d_done: got edge %0d count %0d, want edge %0d count 1", r, done_e, done_cnt, 4 * N); end
    end
  endtask

`ifdef CFG_PARITY_EN
  task automatic test_parity;
    for (int i = 0; i < N; i++) words[i] = $urandom;
    words[2] = 32'h0000_0001;
    bad_idx = 2;
    run_load(-1, 0, 1'b0, 20);
    bad_idx = -1;
    tests++; if (io_err !== 1'b1) begin fails++; $display("FAIL par_err: got %b, want 1", io_err); end
    tests++; if (obs_pos.size() != 2) begin fails++; $display("FAIL par_strobes: got %0d strobes, want 2", obs_pos.size()); end
    tests++; if (done_cnt != 0 || io_busy !== 1'b0) begin fails++; $display("FAIL par_idle: got done_cnt=%0d busy=%b, want 0 0", done_cnt, io_busy); end
    tests++; if (io_d_out !== words[1]) begin fails++; $display("FAIL par_dout: got %h, want %h", io_d_out, words[1]); end
    io_start = 1'b1;
    @(negedge clk);
    io_start = 1'b0;
    tests++; if (io_err !== 1'b0 || io_busy !== 1'b1) begin fails++; $display("FAIL par_clear: got err=%b busy=%b, want 0 1", io_err, io_busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_reset_mid();
    test_start_noise();
    test_back_to_back();
`ifdef CFG_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
